// File: rtl/multiplier_pkg.sv
// Shared types and defaults for the shift-add multiplier controller.
// Optional feature macro used by the controller: MULT_CTRL_EARLY_TERM_EN.
package multiplier_pkg;

  localparam int WORD_LENGTH_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } mult_state_t;

  // Width of a counter that must reach the value wl inclusive.
  function automatic int count_width(input int wl);
    return $clog2(wl + 1);
  endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Iteration counter: synchronous clear, increment, and a flag that is high when
// the next increment lands on TERMINAL.
module mult_bit_counter #(
  parameter int TERMINAL = 2,
  parameter int CW       = $clog2(TERMINAL + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  localparam logic [CW:0] TC_VAL = (CW + 1)'(TERMINAL);

  logic [CW-1:0] r_count;
  logic [CW:0]   w_count_inc;

  // One bit wider so the terminal compare cannot wrap.
  assign w_count_inc = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};
  assign o_tc        = (w_count_inc == TC_VAL);
  assign o_count     = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_count_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/multiplier_controller.sv
// Sequencer for a serial shift-add multiplier datapath.
// Define MULT_CTRL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start, all strobes low
// ST_LOAD  | load operands, clear product, zero the iteration count
// ST_ADD   | conditionally accumulate the multiplicand (multiplier LSB)
// ST_SHIFT | shift multiplier and product, count one iteration
// ST_DONE  | one-cycle product-valid pulse
module multiplier_controller
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT,
  parameter int CW          = count_width(WORD_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          multiplierLsb,
  input  logic          multiplierZero,
  output logic          load,
  output logic          clear,
  output logic          add,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bitCount
);

  mult_state_t r_state;
  mult_state_t w_state_next;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_cnt_tc;
  logic        w_early_term;

`ifdef MULT_CTRL_EARLY_TERM_EN
  assign w_early_term = multiplierZero;
`else
  logic w_unused_zero;
  assign w_unused_zero = multiplierZero;
  assign w_early_term  = 1'b0;
`endif

  assign w_cnt_clr = (r_state == ST_LOAD);
  assign w_cnt_inc = (r_state == ST_SHIFT);

  mult_bit_counter #(
    .TERMINAL (WORD_LENGTH),
    .CW       (CW)
  ) u_bit_counter (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_count (bitCount),
    .o_tc    (w_cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_ADD;
      ST_ADD:   w_state_next = w_early_term ? ST_DONE : ST_SHIFT;
      ST_SHIFT: w_state_next = w_cnt_tc ? ST_DONE : ST_ADD;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Strobes depend only on state; add additionally follows the multiplier LSB.
  always_comb begin
    load  = 1'b0;
    clear = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    done  = 1'b0;
    busy  = (r_state != ST_IDLE);
    case (r_state)
      ST_LOAD: begin
        load  = 1'b1;
        clear = 1'b1;
      end
      ST_ADD:   add   = multiplierLsb & ~w_early_term;
      ST_SHIFT: shift = 1'b1;
      ST_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/multiplier_controller.md
MULTIPLIER_CONTROLLER -- requirements
Module: multiplier_controller

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 2, meaning the operand width in bits, which is also the number of shift-add iterations.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new multiplication.
REQ-005 The block SHALL have port multiplierLsb, input, 1 bit: current serialOutput bit of the multiplier shift register.
REQ-006 The block SHALL have port multiplierZero, input, 1 bit: high when the remaining multiplier bits are all zero.
REQ-007 The block SHALL have port load, output, 1 bit: parallel-load the operand registers.
REQ-008 The block SHALL have port clear, output, 1 bit: zero the product accumulator.
REQ-009 The block SHALL have port add, output, 1 bit: accumulate the multiplicand into the product.
REQ-010 The block SHALL have port shift, output, 1 bit: shift the multiplier right and the product right.
REQ-011 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the product as valid.
REQ-013 The block SHALL have port bitCount, output, $clog2(WORD_LENGTH+1) bits: iterations completed.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, ADD, SHIFT and DONE.
REQ-015 In IDLE, start=1 sampled at edge k SHALL enter LOAD for cycle k+1; start=0 keeps IDLE.
REQ-016 LOAD SHALL assert load=1 and clear=1 for exactly one cycle, reset bitCount to 0, then go to ADD.
REQ-017 ADD SHALL assert add=multiplierLsb for one cycle, then go to SHIFT.
REQ-018 SHIFT SHALL assert shift=1 for one cycle and increment bitCount; when the incremented value equals WORD_LENGTH it goes to DONE, otherwise to ADD.
REQ-019 DONE SHALL assert done=1 for one cycle, then go to IDLE; bitCount holds its value until the next LOAD.
REQ-020 busy SHALL be 1 in LOAD, ADD, SHIFT and DONE, and 0 in IDLE.
REQ-021 With no early termination, done SHALL rise 2*WORD_LENGTH+2 cycles after start is sampled (6 cycles for WORD_LENGTH=2).
REQ-022 start SHALL be ignored while busy=1; no queuing.
REQ-023 start held high through DONE SHALL begin a new LOAD only in the cycle after IDLE is re-entered.
REQ-024 load, clear, add and shift SHALL be mutually exclusive, except load with clear in LOAD.
REQ-025 All outputs SHALL be registered or decoded purely from state; no combinational path from start to any output.

Reset
REQ-026 While reset=1 at a rising edge, the state SHALL become IDLE and bitCount 0; load, clear, add, shift, busy and done SHALL be 0 in the following cycle.
REQ-027 reset SHALL take priority over start and over any in-flight operation; an aborted operation produces no done.

Configuration
REQ-028 Macro MULT_CTRL_EARLY_TERM_EN SHALL control early termination.
REQ-029 With MULT_CTRL_EARLY_TERM_EN defined, ADD with multiplierZero=1 SHALL assert add=0 and go directly to DONE; bitCount keeps its current value.
REQ-030 Without MULT_CTRL_EARLY_TERM_EN, multiplierZero SHALL be ignored; the port is always present.

Structure
REQ-031 Package multiplier_pkg SHALL hold the state enum type and the default WORD_LENGTH constant.
REQ-032 The iteration counter SHALL be sub-module mult_bit_counter, with clear, increment and terminal-count output.

Verification (WORD_LENGTH=2)
REQ-033 Reset, then start pulse at edge 0 -> load=clear=1 in cycle 1; add/shift alternate in cycles 2-5; done=1 in cycle 6; busy=0 in cycle 7.
REQ-034 multiplierLsb sequence 1,0 -> add=1 in cycle 2 and add=0 in cycle 4; shift=1 in cycles 3 and 5; bitCount=2 at done.
REQ-035 start re-pulsed in cycle 3 -> ignored; exactly one done, in cycle 6.
REQ-036 reset asserted in cycle 4 -> all outputs 0 from cycle 5; no done; a new start then completes normally.
REQ-037 With MULT_CTRL_EARLY_TERM_EN defined and multiplierZero=1 at cycle 4 -> done in cycle 5 with bitCount=1; with the macro undefined -> done in cycle 6.
REQ-038 start held high continuously -> back-to-back operations, with load pulses 7 cycles apart.
